// File: rtl/jb_prach_ant_sched.sv
// PRACH antenna scheduler: collects one sample per antenna into holding registers,
// then serialises them as a contiguous burst tagged with the antenna index.
module jb_prach_ant_sched #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                     clk_4x,
  input  logic                     reset_4x,
  input  logic                     enable,
  input  logic [N_ANTENNAS-1:0]    ant_tvalid_in,
  input  logic [2*PRECISION-1:0]   ant_tdata_in [N_ANTENNAS-1:0],
  input  logic                     err_clr,
  output logic                     tvalid_out,
  output logic [2*PRECISION-1:0]   tdata_out,
  output logic [USR_ID_BW-1:0]     tuser_out,
  output logic [N_ANTENNAS-1:0]    ovf_sticky,
  output logic                     udf_sticky,
  output logic [15:0]              slot_cnt
);

  localparam int CntW = $clog2(TIMEOUT + 1);

  generate
    if (N_ANTENNAS > 2**USR_ID_BW) begin : g_badIdWidth
      $error("jb_prach_ant_sched: USR_ID_BW too narrow for N_ANTENNAS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                   r_state;
  logic [USR_ID_BW-1:0]     r_idx;
  logic [N_ANTENNAS-1:0]    r_full;
  logic [2*PRECISION-1:0]   r_hold [N_ANTENNAS-1:0];
  logic [CntW-1:0]          r_toCnt;
  logic                     r_tvalid;
  logic [2*PRECISION-1:0]   r_tdata;
  logic [USR_ID_BW-1:0]     r_tuser;
  logic [N_ANTENNAS-1:0]    r_ovf;
  logic                     r_udf;
  logic [15:0]              r_slotCnt;

  logic [N_ANTENNAS-1:0]    w_drain;
  logic [N_ANTENNAS-1:0]    w_load;
  logic [N_ANTENNAS-1:0]    w_ovfSet;
  logic                     w_lastBeat;
  logic                     w_udfSet;

  // A slot being drained this cycle may be refilled in the same cycle;
  // anything else arriving on a full slot is dropped and flagged.
  always_comb begin
    w_drain  = '0;
    w_load   = '0;
    w_ovfSet = '0;
    if (r_state == SEND) begin
      w_drain[r_idx] = 1'b1;
    end
    if (enable && (r_state != IDLE)) begin
      for (int i = 0; i < N_ANTENNAS; i++) begin
        if (ant_tvalid_in[i]) begin
          if (!r_full[i] || w_drain[i]) begin
            w_load[i] = 1'b1;
          end else begin
            w_ovfSet[i] = 1'b1;
          end
        end
      end
    end
  end

  assign w_lastBeat = (r_state == SEND) && (r_idx == USR_ID_BW'(N_ANTENNAS - 1));
  assign w_udfSet   = (r_state == WAIT) && enable && (|r_full) && !(&r_full) &&
                      (r_toCnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_full    <= '0;
      r_toCnt   <= '0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_ovf     <= '0;
      r_udf     <= 1'b0;
      r_slotCnt <= '0;
      for (int i = 0; i < N_ANTENNAS; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_tvalid  <= 1'b0;
      r_ovf     <= (err_clr ? '0 : r_ovf) | w_ovfSet;
      r_udf     <= (r_udf & ~err_clr) | w_udfSet;
      r_slotCnt <= r_slotCnt + {15'd0, w_lastBeat};
      for (int i = 0; i < N_ANTENNAS; i++) begin
        if (w_load[i]) begin
          r_hold[i] <= ant_tdata_in[i];
        end
      end
      case (r_state)
        IDLE: begin
          r_full  <= '0;
          r_toCnt <= '0;
          r_idx   <= '0;
          if (enable) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_full  <= '0;
            r_toCnt <= '0;
          end else if (&r_full) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_toCnt <= '0;
          end else if (|r_full) begin
            // Partial slot timed out: discard it and start collecting afresh.
            if (w_udfSet) begin
              r_full  <= w_load;
              r_toCnt <= '0;
            end else begin
              r_full  <= r_full | w_load;
              r_toCnt <= r_toCnt + 1'b1;
            end
          end else begin
            r_full <= w_load;
          end
        end
        SEND: begin
          r_tvalid <= 1'b1;
          r_tdata  <= r_hold[r_idx];
          r_tuser  <= r_idx;
          r_full   <= (r_full & ~w_drain) | w_load;
          if (w_lastBeat) begin
            r_idx   <= '0;
            r_state <= enable ? WAIT : IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tvalid_out = r_tvalid;
  assign tdata_out  = r_tdata;
  assign tuser_out  = r_tuser;
  assign ovf_sticky = r_ovf;
  assign udf_sticky = r_udf;
  assign slot_cnt   = r_slotCnt;

endmodule

// File: tb/tb_jb_prach_ant_sched.sv
// Directed bench for jb_prach_ant_sched with default parameters (4 antennas, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_jb_prach_ant_sched;

  logic        clk_4x = 1'b0;
  logic        reset_4x;
  logic        enable;
  logic [3:0]  ant_tvalid_in;
  logic [31:0] ant_tdata_in [3:0];
  logic        err_clr;
  logic        tvalid_out;
  logic [31:0] tdata_out;
  logic [1:0]  tuser_out;
  logic [3:0]  ovf_sticky;
  logic        udf_sticky;
  logic [15:0] slot_cnt;

  int checkCount = 0;
  int passCount  = 0;

  jb_prach_ant_sched #(
    .N_ANTENNAS(4),
    .PRECISION(16),
    .USR_ID_BW(2),
    .TIMEOUT(8)
  ) dut (
    .clk_4x(clk_4x),
    .reset_4x(reset_4x),
    .enable(enable),
    .ant_tvalid_in(ant_tvalid_in),
    .ant_tdata_in(ant_tdata_in),
    .err_clr(err_clr),
    .tvalid_out(tvalid_out),
    .tdata_out(tdata_out),
    .tuser_out(tuser_out),
    .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky),
    .slot_cnt(slot_cnt)
  );

  // 10 ns clock period.
  always #5 clk_4x = ~clk_4x;

  // Hard stop so a stuck run still reports instead of hanging.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, need completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setData(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    ant_tdata_in[0] = d0;
    ant_tdata_in[1] = d1;
    ant_tdata_in[2] = d2;
    ant_tdata_in[3] = d3;
  endtask

  // Hold reset for two cycles and confirm every output is cleared, then enter WAIT.
  task automatic test_reset();
    reset_4x = 1'b1;
    enable = 1'b0;
    err_clr = 1'b0;
    ant_tvalid_in = 4'h0;
    setData(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b need 0", tvalid_out); else passCount++;
    checkCount++;
    if (tdata_out !== 32'h0) $display("[TB] FAIL reset_tdata: got %h need 0", tdata_out); else passCount++;
    checkCount++;
    if (tuser_out !== 2'd0) $display("[TB] FAIL reset_tuser: got %0d need 0", tuser_out); else passCount++;
    checkCount++;
    if (ovf_sticky !== 4'h0 || udf_sticky !== 1'b0)
      $display("[TB] FAIL reset_sticky: got ovf=%b udf=%b need 0000/0", ovf_sticky, udf_sticky);
    else passCount++;
    checkCount++;
    if (slot_cnt !== 16'd0) $display("[TB] FAIL reset_slot_cnt: got %0d need 0", slot_cnt); else passCount++;
    reset_4x = 1'b0;
    enable = 1'b1;
    @(negedge clk_4x);
  endtask

  // All four antennas arrive together; beats follow two edges later in index order.
  task automatic test_basic();
    logic [31:0] expData [4];
    expData = '{32'h11, 32'h22, 32'h33, 32'h44};
    setData(32'h11, 32'h22, 32'h33, 32'h44);
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b0) $display("[TB] FAIL basic_latency: got tvalid=%b at E+1 need 0", tvalid_out); else passCount++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4x);
      checkCount++;
      if (tvalid_out !== 1'b1 || tuser_out !== 2'(k) || tdata_out !== expData[k])
        $display("[TB] FAIL basic_beat%0d: got v=%b u=%0d d=%h need v=1 u=%0d d=%h",
                 k, tvalid_out, tuser_out, tdata_out, k, expData[k]);
      else passCount++;
    end
    checkCount++;
    if (slot_cnt !== 16'd1) $display("[TB] FAIL basic_slot_cnt: got %0d need 1", slot_cnt); else passCount++;
    @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b0 || tuser_out !== 2'd3 || tdata_out !== 32'h44)
      $display("[TB] FAIL basic_hold: got v=%b u=%0d d=%h need v=0 u=3 d=44", tvalid_out, tuser_out, tdata_out);
    else passCount++;
  endtask

  // Antenna 3 never arrives: underflow after TIMEOUT cycles and the partial slot is discarded.
  task automatic test_timeout();
    int beats;
    beats = 0;
    setData(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    ant_tvalid_in = 4'b0111;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (7) begin
      @(negedge clk_4x);
      if (tvalid_out) beats++;
    end
    checkCount++;
    if (udf_sticky !== 1'b0) $display("[TB] FAIL timeout_early: got udf=%b at E+7 need 0", udf_sticky); else passCount++;
    @(negedge clk_4x);
    if (tvalid_out) beats++;
    checkCount++;
    if (udf_sticky !== 1'b1) $display("[TB] FAIL timeout_udf: got udf=%b at E+8 need 1", udf_sticky); else passCount++;
    // Supplying only antenna 3 must not complete a slot if the old flags were cleared.
    ant_tvalid_in = 4'b1000;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (8) begin
      @(negedge clk_4x);
      if (tvalid_out) beats++;
    end
    checkCount++;
    if (beats !== 0) $display("[TB] FAIL timeout_no_beats: got %0d beats need 0", beats); else passCount++;
    err_clr = 1'b1;
    @(negedge clk_4x);
    err_clr = 1'b0;
    checkCount++;
    if (udf_sticky !== 1'b0) $display("[TB] FAIL timeout_errclr: got udf=%b need 0", udf_sticky); else passCount++;
  endtask

  // Second sample on antenna 1 is dropped and flagged; the first one is emitted.
  task automatic test_overflow();
    logic [31:0] expData [4];
    expData = '{32'hC0, 32'hA1, 32'hC2, 32'hC3};
    setData(32'h0, 32'hA1, 32'h0, 32'h0);
    ant_tvalid_in = 4'b0010;
    @(negedge clk_4x);
    setData(32'h0, 32'hB2, 32'h0, 32'h0);
    @(negedge clk_4x);
    checkCount++;
    if (ovf_sticky !== 4'b0010) $display("[TB] FAIL ovf_flag: got %b need 0010", ovf_sticky); else passCount++;
    setData(32'hC0, 32'hEE, 32'hC2, 32'hC3);
    ant_tvalid_in = 4'b1101;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    @(negedge clk_4x);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4x);
      checkCount++;
      if (tvalid_out !== 1'b1 || tuser_out !== 2'(k) || tdata_out !== expData[k])
        $display("[TB] FAIL ovf_beat%0d: got v=%b u=%0d d=%h need v=1 u=%0d d=%h",
                 k, tvalid_out, tuser_out, tdata_out, k, expData[k]);
      else passCount++;
    end
    checkCount++;
    if (slot_cnt !== 16'd2) $display("[TB] FAIL ovf_slot_cnt: got %0d need 2", slot_cnt); else passCount++;
    err_clr = 1'b1;
    @(negedge clk_4x);
    err_clr = 1'b0;
    checkCount++;
    if (ovf_sticky !== 4'h0) $display("[TB] FAIL ovf_errclr: got %b need 0000", ovf_sticky); else passCount++;
  endtask

  // Next slot is refilled during the burst, including on the draining cycle itself.
  task automatic test_back_to_back();
    logic [31:0] expX [4];
    logic [31:0] expY [4];
    expX = '{32'h1000, 32'h1001, 32'h1002, 32'h1003};
    expY = '{32'h2000, 32'h2001, 32'h2002, 32'h2003};
    setData(32'h1000, 32'h1001, 32'h1002, 32'h1003);
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    @(negedge clk_4x);
    setData(32'h2000, 32'h2001, 32'h2002, 32'h2003);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4x);
      checkCount++;
      if (tvalid_out !== 1'b1 || tuser_out !== 2'(k) || tdata_out !== expX[k])
        $display("[TB] FAIL b2b_x_beat%0d: got v=%b u=%0d d=%h need v=1 u=%0d d=%h",
                 k, tvalid_out, tuser_out, tdata_out, k, expX[k]);
      else passCount++;
      if (k == 0) ant_tvalid_in = 4'b0011;
      else if (k == 1) ant_tvalid_in = 4'b0100;
      else if (k == 2) ant_tvalid_in = 4'b1000;
      else ant_tvalid_in = 4'b0000;
    end
    @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b0) $display("[TB] FAIL b2b_gap: got tvalid=%b need 0", tvalid_out); else passCount++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4x);
      checkCount++;
      if (tvalid_out !== 1'b1 || tuser_out !== 2'(k) || tdata_out !== expY[k])
        $display("[TB] FAIL b2b_y_beat%0d: got v=%b u=%0d d=%h need v=1 u=%0d d=%h",
                 k, tvalid_out, tuser_out, tdata_out, k, expY[k]);
      else passCount++;
    end
    checkCount++;
    if (ovf_sticky !== 4'h0 || slot_cnt !== 16'd4)
      $display("[TB] FAIL b2b_status: got ovf=%b slot=%0d need 0000/4", ovf_sticky, slot_cnt);
    else passCount++;
  endtask

  // Dropping enable mid-burst finishes the slot, then inputs are ignored until re-enabled.
  task automatic test_enable_drop();
    int beats;
    beats = 0;
    setData(32'h3000, 32'h3001, 32'h3002, 32'h3003);
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (3) @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b1 || tuser_out !== 2'd1)
      $display("[TB] FAIL endrop_beat1: got v=%b u=%0d need v=1 u=1", tvalid_out, tuser_out);
    else passCount++;
    enable = 1'b0;
    @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b1 || tuser_out !== 2'd2 || tdata_out !== 32'h3002)
      $display("[TB] FAIL endrop_beat2: got v=%b u=%0d d=%h need v=1 u=2 d=3002", tvalid_out, tuser_out, tdata_out);
    else passCount++;
    @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b1 || tuser_out !== 2'd3 || tdata_out !== 32'h3003 || slot_cnt !== 16'd5)
      $display("[TB] FAIL endrop_beat3: got v=%b u=%0d d=%h slot=%0d need v=1 u=3 d=3003 slot=5",
               tvalid_out, tuser_out, tdata_out, slot_cnt);
    else passCount++;
    setData(32'h4000, 32'h4001, 32'h4002, 32'h4003);
    ant_tvalid_in = 4'hF;
    repeat (2) begin
      @(negedge clk_4x);
      if (tvalid_out) beats++;
    end
    ant_tvalid_in = 4'h0;
    enable = 1'b1;
    repeat (6) begin
      @(negedge clk_4x);
      if (tvalid_out) beats++;
    end
    checkCount++;
    if (beats !== 0 || ovf_sticky !== 4'h0)
      $display("[TB] FAIL endrop_idle_ignore: got beats=%0d ovf=%b need 0/0000", beats, ovf_sticky);
    else passCount++;
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (2) @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b1 || tuser_out !== 2'd0 || tdata_out !== 32'h4000)
      $display("[TB] FAIL endrop_resume: got v=%b u=%0d d=%h need v=1 u=0 d=4000", tvalid_out, tuser_out, tdata_out);
    else passCount++;
    repeat (3) @(negedge clk_4x);
    checkCount++;
    if (slot_cnt !== 16'd6) $display("[TB] FAIL endrop_slot_cnt: got %0d need 6", slot_cnt); else passCount++;
  endtask

  // Reset during beat 2 clears outputs at once and no leftover beats follow release.
  task automatic test_reset_midburst();
    int beats;
    beats = 0;
    setData(32'h5000, 32'h5001, 32'h5002, 32'h5003);
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (4) @(negedge clk_4x);
    checkCount++;
    if (tvalid_out !== 1'b1 || tuser_out !== 2'd2)
      $display("[TB] FAIL rstmid_beat2: got v=%b u=%0d need v=1 u=2", tvalid_out, tuser_out);
    else passCount++;
    reset_4x = 1'b1;
    #1;
    checkCount++;
    if (tvalid_out !== 1'b0 || tdata_out !== 32'h0 || tuser_out !== 2'd0 || slot_cnt !== 16'd0)
      $display("[TB] FAIL rstmid_async: got v=%b d=%h u=%0d slot=%0d need all 0",
               tvalid_out, tdata_out, tuser_out, slot_cnt);
    else passCount++;
    @(negedge clk_4x);
    reset_4x = 1'b0;
    repeat (6) begin
      @(negedge clk_4x);
      if (tvalid_out) beats++;
    end
    checkCount++;
    if (beats !== 0) $display("[TB] FAIL rstmid_residual: got %0d beats need 0", beats); else passCount++;
  endtask

  // Counter preloaded to 0xFFFF (standing in for 65535 completed slots) wraps on the next slot.
  task automatic test_wrap();
    force dut.r_slotCnt = 16'hFFFF;
    @(negedge clk_4x);
    release dut.r_slotCnt;
    setData(32'h6000, 32'h6001, 32'h6002, 32'h6003);
    ant_tvalid_in = 4'hF;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    repeat (4) @(negedge clk_4x);
    checkCount++;
    if (slot_cnt !== 16'hFFFF) $display("[TB] FAIL wrap_pre: got %h need ffff", slot_cnt); else passCount++;
    @(negedge clk_4x);
    checkCount++;
    if (slot_cnt !== 16'h0000 || tvalid_out !== 1'b1 || tuser_out !== 2'd3)
      $display("[TB] FAIL wrap_slot_cnt: got slot=%h v=%b u=%0d need 0000/1/3", slot_cnt, tvalid_out, tuser_out);
    else passCount++;
  endtask

  // err_clr in the same cycle as a fresh overflow leaves the flag set.
  task automatic test_errclr_collide();
    @(negedge clk_4x);
    setData(32'h7000, 32'h7001, 32'h7002, 32'h7003);
    ant_tvalid_in = 4'b0100;
    @(negedge clk_4x);
    err_clr = 1'b1;
    @(negedge clk_4x);
    ant_tvalid_in = 4'h0;
    err_clr = 1'b0;
    checkCount++;
    if (ovf_sticky !== 4'b0100) $display("[TB] FAIL collide_set_wins: got %b need 0100", ovf_sticky); else passCount++;
    err_clr = 1'b1;
    @(negedge clk_4x);
    err_clr = 1'b0;
    checkCount++;
    if (ovf_sticky !== 4'h0) $display("[TB] FAIL collide_clear: got %b need 0000", ovf_sticky); else passCount++;
  endtask

  // Scenario sequence; each task starts and ends on a falling edge with the FSM in WAIT.
  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_enable_drop();
    test_reset_midburst();
    test_wrap();
    test_errclr_collide();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
